// File: rtl/instruction_fetch_unit_if.sv
// Bundles the IF stage's control inputs, instruction-memory port and IF/ID register outputs.
// The master modport is the fetch unit's view; slave is the surrounding pipeline and memory.
interface instruction_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic [31:0] instruction_id;
  logic        valid_id;
  logic [31:0] fetch_count;

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  imem_instruction,
    output imem_address,
    output pc_id,
    output pc_plus4_id,
    output instruction_id,
    output valid_id,
    output fetch_count
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    output imem_instruction,
    input  imem_address,
    input  pc_id,
    input  pc_plus4_id,
    input  instruction_id,
    input  valid_id,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage of the RV32IM pipeline: owns the PC, fetches from combinational instruction memory
// and fills the IF/ID register, inserting NOP bubbles on redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic                        clk,
  input logic                        reset_n,
  instruction_fetch_unit_if.master   fetch_bus
);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
  logic [31:0] instruction_id_q, instruction_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect beats stall: a wrong-path instruction must never survive a held stage.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pc_id_d          = pc_id_q;
    pc_plus4_id_d    = pc_plus4_id_q;
    instruction_id_d = instruction_id_q;
    valid_id_d       = valid_id_q;
    fetch_count_d    = fetch_count_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (fetch_bus.branch_taken) begin
          pc_d             = {fetch_bus.branch_target[31:2], 2'b00};
          instruction_id_d = NOP_INSTR;
          valid_id_d       = 1'b0;
        end else if (!fetch_bus.stall) begin
          pc_d             = pc_plus4;
          pc_id_d          = pc_q;
          pc_plus4_id_d    = pc_plus4;
          instruction_id_d = fetch_bus.imem_instruction;
          valid_id_d       = 1'b1;
          fetch_count_d    = fetch_count_q + 32'd1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q             <= RESET_PC;
      pc_id_q          <= 32'd0;
      pc_plus4_id_q    <= 32'd0;
      instruction_id_q <= NOP_INSTR;
      valid_id_q       <= 1'b0;
      fetch_count_q    <= 32'd0;
    end else begin
      pc_q             <= pc_d;
      pc_id_q          <= pc_id_d;
      pc_plus4_id_q    <= pc_plus4_id_d;
      instruction_id_q <= instruction_id_d;
      valid_id_q       <= valid_id_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  assign fetch_bus.imem_address   = pc_q;
  assign fetch_bus.pc_id          = pc_id_q;
  assign fetch_bus.pc_plus4_id    = pc_plus4_id_q;
  assign fetch_bus.instruction_id = instruction_id_q;
  assign fetch_bus.valid_id       = valid_id_q;
  assign fetch_bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: boot, stall, redirect, priority, PC wrap and
// asynchronous reset, against hand-computed expectations and a small instruction ROM.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC  (32'h00000000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fetch_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM: two real words at 0 and 4, an address-tagged pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h00000000: mem_word = 32'h00000093;
      32'h00000004: mem_word = 32'h00100113;
      default:      mem_word = {8'hA5, addr[23:0]};
    endcase
  endfunction

  always_comb bus.imem_instruction = mem_word(bus.imem_address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    #12;
    checks++;
    if (bus.imem_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", bus.imem_address, 32'h0); end
    checks++;
    if (bus.valid_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_id); end
    checks++;
    if (bus.instruction_id !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", bus.instruction_id, NOP); end
    checks++;
    if (bus.fetch_count !== 32'h0 || bus.pc_id !== 32'h0 || bus.pc_plus4_id !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_regs: got cnt=%h pc_id=%h pc4=%h expected all 0", bus.fetch_count, bus.pc_id, bus.pc_plus4_id);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (bus.imem_address !== 32'h0 || bus.valid_id !== 1'b0) begin
      errors++; $display("[TB] FAIL boot_edge: got addr=%h valid=%b expected addr=0 valid=0", bus.imem_address, bus.valid_id);
    end
    tick();
    checks++;
    if (bus.instruction_id !== 32'h00000093 || bus.pc_id !== 32'h0 || bus.pc_plus4_id !== 32'h4 || bus.valid_id !== 1'b1) begin
      errors++; $display("[TB] FAIL first_fetch: got instr=%h pc_id=%h pc4=%h valid=%b expected 00000093/0/4/1",
                         bus.instruction_id, bus.pc_id, bus.pc_plus4_id, bus.valid_id);
    end
    tick();
    checks++;
    if (bus.instruction_id !== 32'h00100113 || bus.pc_id !== 32'h4 || bus.fetch_count !== 32'd2) begin
      errors++; $display("[TB] FAIL second_fetch: got instr=%h pc_id=%h cnt=%0d expected 00100113/4/2",
                         bus.instruction_id, bus.pc_id, bus.fetch_count);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.imem_address !== 32'h24 || bus.fetch_count !== 32'd9) begin
      errors++; $display("[TB] FAIL stall_setup: got addr=%h cnt=%0d expected 24/9", bus.imem_address, bus.fetch_count);
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.imem_address !== 32'h24 || bus.pc_id !== 32'h20 || bus.instruction_id !== mem_word(32'h20) ||
          bus.fetch_count !== 32'd9 || bus.valid_id !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_hold: got addr=%h pc_id=%h instr=%h cnt=%0d valid=%b expected 24/20/%h/9/1",
                           bus.imem_address, bus.pc_id, bus.instruction_id, bus.fetch_count, bus.valid_id, mem_word(32'h20));
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.instruction_id !== mem_word(32'h24) || bus.pc_id !== 32'h24 || bus.fetch_count !== 32'd10 || bus.imem_address !== 32'h28) begin
      errors++; $display("[TB] FAIL stall_release: got instr=%h pc_id=%h cnt=%0d addr=%h expected %h/24/10/28",
                         bus.instruction_id, bus.pc_id, bus.fetch_count, bus.imem_address, mem_word(32'h24));
    end
  endtask

  task automatic test_redirect();
    tick();
    tick();
    checks++;
    if (bus.imem_address !== 32'h30) begin errors++; $display("[TB] FAIL redirect_setup: got %h expected 30", bus.imem_address); end
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h44;
    tick();
    checks++;
    if (bus.instruction_id !== NOP || bus.valid_id !== 1'b0 || bus.imem_address !== 32'h44 ||
        bus.fetch_count !== 32'd12 || bus.pc_id !== 32'h2C) begin
      errors++; $display("[TB] FAIL redirect_bubble: got instr=%h valid=%b addr=%h cnt=%0d pc_id=%h expected %h/0/44/12/2c",
                         bus.instruction_id, bus.valid_id, bus.imem_address, bus.fetch_count, bus.pc_id, NOP);
    end
    bus.branch_taken = 1'b0;
    tick();
    checks++;
    if (bus.pc_id !== 32'h44 || bus.valid_id !== 1'b1 || bus.imem_address !== 32'h48 ||
        bus.instruction_id !== mem_word(32'h44) || bus.fetch_count !== 32'd13) begin
      errors++; $display("[TB] FAIL redirect_target: got pc_id=%h valid=%b addr=%h instr=%h cnt=%0d expected 44/1/48/%h/13",
                         bus.pc_id, bus.valid_id, bus.imem_address, bus.instruction_id, bus.fetch_count, mem_word(32'h44));
    end
  endtask

  task automatic test_simultaneous();
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h47;
    tick();
    checks++;
    if (bus.imem_address !== 32'h44 || bus.valid_id !== 1'b0 || bus.instruction_id !== NOP ||
        bus.fetch_count !== 32'd13 || bus.pc_id !== 32'h44) begin
      errors++; $display("[TB] FAIL simul_priority: got addr=%h valid=%b instr=%h cnt=%0d pc_id=%h expected 44/0/%h/13/44",
                         bus.imem_address, bus.valid_id, bus.instruction_id, bus.fetch_count, bus.pc_id, NOP);
    end
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    tick();
    checks++;
    if (bus.pc_id !== 32'h44 || bus.fetch_count !== 32'd14 || bus.imem_address !== 32'h48 || bus.valid_id !== 1'b1) begin
      errors++; $display("[TB] FAIL simul_resume: got pc_id=%h cnt=%0d addr=%h valid=%b expected 44/14/48/1",
                         bus.pc_id, bus.fetch_count, bus.imem_address, bus.valid_id);
    end
  endtask

  task automatic test_pc_wrap();
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'hFFFFFFFC;
    tick();
    checks++;
    if (bus.imem_address !== 32'hFFFFFFFC || bus.valid_id !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_redirect: got addr=%h valid=%b expected fffffffc/0", bus.imem_address, bus.valid_id);
    end
    bus.branch_taken = 1'b0;
    tick();
    checks++;
    if (bus.pc_id !== 32'hFFFFFFFC || bus.pc_plus4_id !== 32'h0 || bus.imem_address !== 32'h0 || bus.fetch_count !== 32'd15) begin
      errors++; $display("[TB] FAIL wrap_fetch: got pc_id=%h pc4=%h addr=%h cnt=%0d expected fffffffc/0/0/15",
                         bus.pc_id, bus.pc_plus4_id, bus.imem_address, bus.fetch_count);
    end
    tick();
    checks++;
    if (bus.imem_address !== 32'h4 || bus.pc_id !== 32'h0 || bus.instruction_id !== 32'h00000093 || bus.fetch_count !== 32'd16) begin
      errors++; $display("[TB] FAIL wrap_after: got addr=%h pc_id=%h instr=%h cnt=%0d expected 4/0/00000093/16",
                         bus.imem_address, bus.pc_id, bus.instruction_id, bus.fetch_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h50;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.imem_address !== 32'h58 || bus.valid_id !== 1'b1 || bus.fetch_count !== 32'd18) begin
      errors++; $display("[TB] FAIL midreset_setup: got addr=%h valid=%b cnt=%0d expected 58/1/18",
                         bus.imem_address, bus.valid_id, bus.fetch_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_address !== 32'h0 || bus.valid_id !== 1'b0 || bus.instruction_id !== NOP ||
        bus.fetch_count !== 32'd0 || bus.pc_id !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_async: got addr=%h valid=%b instr=%h cnt=%0d pc_id=%h expected 0/0/%h/0/0",
                         bus.imem_address, bus.valid_id, bus.instruction_id, bus.fetch_count, bus.pc_id, NOP);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (bus.valid_id !== 1'b0 || bus.imem_address !== 32'h0 || bus.fetch_count !== 32'd0) begin
      errors++; $display("[TB] FAIL midreset_boot: got valid=%b addr=%h cnt=%0d expected 0/0/0",
                         bus.valid_id, bus.imem_address, bus.fetch_count);
    end
    tick();
    checks++;
    if (bus.valid_id !== 1'b1 || bus.instruction_id !== 32'h00000093 || bus.fetch_count !== 32'd1 || bus.imem_address !== 32'h4) begin
      errors++; $display("[TB] FAIL midreset_fetch: got valid=%b instr=%h cnt=%0d addr=%h expected 1/00000093/1/4",
                         bus.valid_id, bus.instruction_id, bus.fetch_count, bus.imem_address);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stall();
    test_redirect();
    test_simultaneous();
    test_pc_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the RV32IM 5-stage pipeline.
- Owns the program counter and drives the byte address into the combinational instruction memory, which returns the word in the same cycle.
- Captures the word into the IF/ID pipeline register.
- Handles load-use stalls from the hazard unit and taken-branch/jump redirects from EX by inserting NOP bubbles.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, encoding (ADDI x0,x0,0) placed in IF/ID for every bubble.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- STALL  input  1  hold PC and IF/ID this cycle (load-use hazard).
- BRANCH_TAKEN  input  1  redirect request from EX.
- BRANCH_TARGET  input  32  redirect byte address.
- IMEM_ADDRESS  output  32  byte address to instruction memory; equals PC.
- IMEM_INSTRUCTION  input  32  word returned combinationally for IMEM_ADDRESS.
- PC_ID  output  32  PC of the instruction in IF/ID.
- PC_PLUS4_ID  output  32  PC_ID+4, for JAL/JALR link.
- INSTRUCTION_ID  output  32  instruction in IF/ID.
- VALID_ID  output  1  1 = real instruction, 0 = bubble.
- FETCH_COUNT  output  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (RESET_N=0, asynchronous, takes effect immediately, including mid-operation):
  - PC=RESET_PC; state=BOOT.
  - PC_ID=0, PC_PLUS4_ID=0, INSTRUCTION_ID=NOP_INSTR, VALID_ID=0, FETCH_COUNT=0.
- FSM: two states, BOOT and RUN.
  - BOOT: one edge only, giving synchronous reset-release settling. At the first rising edge after RESET_N rises: state->RUN, PC unchanged, IF/ID stays a bubble. STALL and BRANCH_TAKEN are ignored in BOOT.
  - RUN: stays in RUN until reset.
- IMEM_ADDRESS = PC, continuously (combinational from the PC register).
- RUN, per rising edge, priority order:
  1. BRANCH_TAKEN=1:
     - PC <= {BRANCH_TARGET[31:2],2'b00}; low two bits are forced to zero.
     - IF/ID <= bubble (INSTRUCTION_ID=NOP_INSTR, VALID_ID=0, PC_ID and PC_PLUS4_ID unchanged).
     - FETCH_COUNT unchanged.
     - Overrides STALL when both are asserted.
  2. STALL=1: PC, IF/ID and FETCH_COUNT all hold.
  3. Otherwise:
     - PC_ID <= PC, PC_PLUS4_ID <= PC+4, INSTRUCTION_ID <= IMEM_INSTRUCTION, VALID_ID <= 1.
     - PC <= PC+4.
     - FETCH_COUNT <= FETCH_COUNT+1.
- Arithmetic: all 32-bit unsigned.
  - PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
  - FETCH_COUNT wraps 32'hFFFFFFFF -> 0.
- Latency: an instruction at PC appears on INSTRUCTION_ID one edge after PC is presented, when not stalled.
- Redirect penalty: the target instruction reaches IF/ID two edges after the BRANCH_TAKEN edge. The first edge inserts the bubble; the second captures the target word.
- The unit never modifies the instruction word, except for the bubble substitution.
- No registered output changes except on a CLK rising edge or on reset assertion.

Test Plan:
- Reset and boot:
  - Stimulus: RESET_N=0, then release; memory holds 0x00000093 at address 0 and 0x00100113 at address 4.
  - Required: IMEM_ADDRESS=0 and VALID_ID=0 through the BOOT edge. Next edge: INSTRUCTION_ID=0x00000093, PC_ID=0, PC_PLUS4_ID=4, VALID_ID=1. Next edge: 0x00100113 with PC_ID=4, FETCH_COUNT=2.
- Stall:
  - Stimulus: assert STALL for 2 edges while PC=0x24.
  - Required: IMEM_ADDRESS stays 0x24; IF/ID and FETCH_COUNT frozen. On release, INSTRUCTION_ID = word at 0x24, PC_ID=0x24.
- Redirect:
  - Stimulus: BRANCH_TAKEN=1, BRANCH_TARGET=0x44 for one edge at PC=0x30.
  - Required: at that edge INSTRUCTION_ID=0x00000013, VALID_ID=0, PC=0x44. Next edge: PC_ID=0x44, VALID_ID=1, PC=0x48.
- Simultaneous events and misaligned target:
  - Stimulus: STALL=1 and BRANCH_TAKEN=1 together with BRANCH_TARGET=0x47.
  - Required: redirect wins; PC=0x44, bubble inserted, FETCH_COUNT unchanged.
- PC wrap:
  - Stimulus: redirect to 0xFFFFFFFC, then run 2 edges.
  - Required: PC_ID=0xFFFFFFFC with PC_PLUS4_ID=0; IMEM_ADDRESS then 0x00000004.
- Reset mid-operation:
  - Stimulus: pull RESET_N low between edges while VALID_ID=1 and PC=0x58.
  - Required: immediately PC=0, VALID_ID=0, INSTRUCTION_ID=0x00000013, FETCH_COUNT=0, with no clock edge needed. After release, the BOOT bubble edge occurs before the first fetch.
